// File: rtl/dmux8way16_stream.sv
// dmux8way16_stream: registered 8-way demultiplexer with valid/ready handshakes.
// One input stream is steered by sel to one of eight one-entry lane registers,
// or copied to all eight lanes when bcast is high. Counts accepted input words.
module dmux8way16_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       sel,
  input  logic             bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  logic [7:0]       full_q;
  logic [WIDTH-1:0] data_q [8];
  logic [CNT_W-1:0] cnt_q;

  logic [7:0] lane_free;
  logic       accept;
  logic [7:0] load;

  // Handshake: a lane can take a word if empty or being drained this cycle.
  // Broadcast needs every lane free so a write is never partial.
  always_comb begin
    lane_free = ~full_q | out_ready;
    in_ready  = ~reset & (bcast ? (&lane_free) : lane_free[sel]);
    accept    = in_valid & in_ready;
  end

  // Decode which lanes are written by this cycle's accepted word.
  always_comb begin
    load = '0;
    if (accept) begin
      if (bcast) begin
        load = '1;
      end else begin
        load[sel] = 1'b1;
      end
    end
  end

  // Lane registers and accept counter; a load wins over a same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (load[i]) begin
          data_q[i] <= in_data;
          full_q[i] <= 1'b1;
        end else if (out_ready[i]) begin
          full_q[i] <= 1'b0;
        end
      end
      if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign a          = data_q[0];
  assign b          = data_q[1];
  assign c          = data_q[2];
  assign d          = data_q[3];
  assign e          = data_q[4];
  assign f          = data_q[5];
  assign g          = data_q[6];
  assign h          = data_q[7];
  assign out_valid  = full_q;
  assign xfer_count = cnt_q;

endmodule
